// File: rtl/bus_datapath_seq.sv
// Single-bus datapath (register file, Y, Z, HI/LO, ALU) with a built-in T1..T4
// sequencer that executes one register-register command per handshake.
module bus_datapath_seq #(
    parameter int  WIDTH   = 32,
    parameter int  NREGS   = 16,
    parameter bit  R0_ZERO = 1'b0,
    localparam int AW      = $clog2(NREGS),
    localparam int SW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [AW-1:0]    cmd_ra,
    input  logic [AW-1:0]    cmd_rb,
    input  logic [AW-1:0]    cmd_rc,
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] bus_out,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SHR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_ROR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_NEG = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;

    localparam logic [SW:0] W_FULL = WIDTH[SW:0];

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    regs [NREGS];
    logic [WIDTH-1:0]    y_q, zhi_q, zlo_q, hi_q, lo_q;
    logic [3:0]          op_q;
    logic [AW-1:0]       ra_q, rb_q, rc_q;
    logic                done_q, div_zero_q;

    logic [WIDTH-1:0]    bus;
    logic [WIDTH-1:0]    src_b, src_c;
    logic                is_long;
    logic                accept;
    logic [SW-1:0]       amt;
    logic [SW:0]         inv_amt;
    logic [2*WIDTH-1:0]  prod;
    logic [WIDTH-1:0]    quot, rem;
    logic [2*WIDTH-1:0]  alu_z;

    assign src_b   = (R0_ZERO && rb_q == '0) ? '0 : regs[rb_q];
    assign src_c   = (R0_ZERO && rc_q == '0) ? '0 : regs[rc_q];
    assign rd_data = (R0_ZERO && rd_addr == '0) ? '0 : regs[rd_addr];

    assign cmd_ready = (state_q == S_IDLE) && !ld_valid && !clr;
    assign accept    = cmd_valid && cmd_ready;
    assign is_long   = (op_q == OP_MUL) || (op_q == OP_DIV);

    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign bus_out  = bus;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        bus = '0;
        case (state_q)
            S_IDLE:  if (ld_valid) bus = ld_data;
            S_T1:    bus = src_b;
            S_T2:    bus = src_c;
            S_T3:    bus = zlo_q;
            S_T4:    bus = zhi_q;
            default: bus = '0;
        endcase
    end

    // ALU: A is Y, B is whatever sits on the bus during T2.
    assign amt     = bus[SW-1:0];
    assign inv_amt = W_FULL - {1'b0, amt};
    assign prod    = {{WIDTH{y_q[WIDTH-1]}}, y_q} * {{WIDTH{bus[WIDTH-1]}}, bus};
    assign quot    = (bus == '0) ? '1  : y_q / bus;
    assign rem     = (bus == '0) ? y_q : y_q % bus;

    always_comb begin
        alu_z = '0;
        case (op_q)
            OP_ADD:  alu_z[WIDTH-1:0] = y_q + bus;
            OP_SUB:  alu_z[WIDTH-1:0] = y_q - bus;
            OP_AND:  alu_z[WIDTH-1:0] = y_q & bus;
            OP_OR:   alu_z[WIDTH-1:0] = y_q | bus;
            OP_SHR:  alu_z[WIDTH-1:0] = y_q >> amt;
            OP_SHL:  alu_z[WIDTH-1:0] = y_q << amt;
            // A shift by the full width yields 0, so amt == 0 degenerates cleanly to A.
            OP_ROR:  alu_z[WIDTH-1:0] = (y_q >> amt) | (y_q << inv_amt);
            OP_ROL:  alu_z[WIDTH-1:0] = (y_q << amt) | (y_q >> inv_amt);
            OP_NEG:  alu_z[WIDTH-1:0] = '0 - y_q;
            OP_NOT:  alu_z[WIDTH-1:0] = ~y_q;
            OP_MUL:  alu_z = prod;
            OP_DIV:  alu_z = {rem, quot};
            default: alu_z = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = is_long ? S_T4 : S_IDLE;
            S_T4:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            // NOTE: the register file is cleared explicitly because reset must zero it, which forces flops rather than RAM.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            state_q    <= S_IDLE;
            y_q        <= '0;
            zhi_q      <= '0;
            zlo_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            op_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            rc_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ld_valid) begin
                        if (!(R0_ZERO && ld_addr == '0)) regs[ld_addr] <= bus;
                    end else if (accept) begin
                        op_q <= cmd_op;
                        ra_q <= cmd_ra;
                        rb_q <= cmd_rb;
                        rc_q <= cmd_rc;
                    end
                end
                S_T1: y_q <= bus;
                S_T2: begin
                    zhi_q <= alu_z[2*WIDTH-1:WIDTH];
                    zlo_q <= alu_z[WIDTH-1:0];
                    if (op_q == OP_DIV) div_zero_q <= (bus == '0);
                end
                S_T3: begin
                    if (is_long) begin
                        lo_q <= bus;
                    end else begin
                        if (!(R0_ZERO && ra_q == '0)) regs[ra_q] <= bus;
                        done_q <= 1'b1;
                    end
                end
                S_T4: begin
                    hi_q   <= bus;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Self-checking bench for bus_datapath_seq: directed vector table, hand-written
// corner sequences and randomized commands against an arithmetic reference model.
module tb_bus_datapath_seq;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          clr, cmd_valid, ld_valid;
    logic [3:0]    cmd_op;
    logic [AW-1:0] cmd_ra, cmd_rb, cmd_rc, ld_addr, rd_addr;
    logic [W-1:0]  ld_data;

    logic          cmd_ready, done, div_zero;
    logic [W-1:0]  bus_out, rd_data, hi_out, lo_out;
    logic          z_cmd_ready, z_done, z_div_zero;
    logic [W-1:0]  z_bus_out, z_rd_data, z_hi_out, z_lo_out;

    always #5 clk = ~clk;

    bus_datapath_seq #(.WIDTH(W), .NREGS(N), .R0_ZERO(1'b0)) dut (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rc(cmd_rc),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .done(done), .div_zero(div_zero), .bus_out(bus_out),
        .rd_addr(rd_addr), .rd_data(rd_data), .hi_out(hi_out), .lo_out(lo_out)
    );

    bus_datapath_seq #(.WIDTH(W), .NREGS(N), .R0_ZERO(1'b1)) dut_z (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(z_cmd_ready),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rc(cmd_rc),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .done(z_done), .div_zero(z_div_zero), .bus_out(z_bus_out),
        .rd_addr(rd_addr), .rd_data(z_rd_data), .hi_out(z_hi_out), .lo_out(z_lo_out)
    );

    int errors = 0;
    int checks = 0;

    // Reference state for the R0_ZERO=0 instance.
    logic [W-1:0] mreg [N];
    logic [W-1:0] m_hi, m_lo;
    logic         m_dz;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, lo, hi;
        logic         dz;
    } vec_t;
    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural ALU: returns {HI/ZHI, LO/ZLO}.
    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        int           sh;
        longint       p;
        sh = int'(b % W);
        r  = a;
        case (op)
            4'd0:  return {32'd0, a + b};
            4'd1:  return {32'd0, a - b};
            4'd2:  return {32'd0, a & b};
            4'd3:  return {32'd0, a | b};
            4'd4:  return {32'd0, a >> sh};
            4'd5:  return {32'd0, a << sh};
            4'd6:  begin repeat (sh) r = {r[0], r[W-1:1]}; return {32'd0, r}; end
            4'd7:  begin repeat (sh) r = {r[W-2:0], r[W-1]}; return {32'd0, r}; end
            4'd8:  return {32'd0, 32'd0 - a};
            4'd9:  return {32'd0, ~a};
            4'd10: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
            4'd11: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) mreg[i] = '0;
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b1; cmd_valid = 1'b0; ld_valid = 1'b0;
        cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rc = '0;
        ld_addr = '0; ld_data = '0; rd_addr = '0;
        tick();
        tick();
        clr = 1'b0;
        model_clear();
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        #1;
        check("ld_bus", bus_out, d);
        tick();
        ld_valid = 1'b0;
        mreg[a] = d;
    endtask

    // Issues one command, follows it through T1..T4 and checks bus, ready, latency and results.
    task automatic run_cmd(input logic [3:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic [AW-1:0] rc);
        logic [63:0] z;
        int          lat, exp_lat;
        bit          long_op;
        rd_addr = ra;
        #1;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rc = rc;
        tick();
        cmd_valid = 1'b0;
        cmd_op = 4'($urandom); cmd_ra = AW'($urandom); cmd_rb = AW'($urandom); cmd_rc = AW'($urandom);
        z       = ref_alu(op, mreg[rb], mreg[rc]);
        long_op = (op == 4'd10) || (op == 4'd11);
        exp_lat = long_op ? 4 : 3;
        lat     = 99;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (done) begin
                lat = c;
                break;
            end
            if (c < 3) check("cmd_ready_busy", cmd_ready, 0);
            case (c)
                0: check("bus_t1", bus_out, mreg[rb]);
                1: check("bus_t2", bus_out, mreg[rc]);
                2: check("bus_t3", bus_out, z[31:0]);
                3: if (long_op) check("bus_t4", bus_out, z[63:32]);
                default: ;
            endcase
            tick();
        end
        check("latency", lat, exp_lat);
        if (long_op) begin
            m_lo = z[31:0];
            m_hi = z[63:32];
            if (op == 4'd11) m_dz = (mreg[rc] == 0);
        end else begin
            mreg[ra] = z[31:0];
        end
        check("rd_ra", rd_data, mreg[ra]);
        check("hi", hi_out, m_hi);
        check("lo", lo_out, m_lo);
        check("div_zero", div_zero, m_dz);
    endtask

    initial begin
        vecs[0]  = '{4'd0,  32'd5,          32'd7,          32'd12,         32'd0,          1'b0};
        vecs[1]  = '{4'd1,  32'd3,          32'd5,          32'hFFFF_FFFE,  32'd0,          1'b0};
        vecs[2]  = '{4'd2,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  32'd0,          1'b0};
        vecs[3]  = '{4'd3,  32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  32'd0,          1'b0};
        vecs[4]  = '{4'd4,  32'h8000_0000,  32'h0000_003F,  32'd1,          32'd0,          1'b0};
        vecs[5]  = '{4'd5,  32'd1,          32'd4,          32'h10,         32'd0,          1'b0};
        vecs[6]  = '{4'd6,  32'd1,          32'd1,          32'h8000_0000,  32'd0,          1'b0};
        vecs[7]  = '{4'd7,  32'h8000_0001,  32'd33,         32'd3,          32'd0,          1'b0};
        vecs[8]  = '{4'd8,  32'd1,          32'd99,         32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[9]  = '{4'd9,  32'h0000_FFFF,  32'd0,          32'hFFFF_0000,  32'd0,          1'b0};
        vecs[10] = '{4'd10, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFA,  32'hFFFF_FFFF,  1'b0};
        vecs[11] = '{4'd11, 32'd17,         32'd0,          32'hFFFF_FFFF,  32'd17,         1'b1};
        vecs[12] = '{4'd11, 32'd17,         32'd5,          32'd3,          32'd2,          1'b0};
        vecs[13] = '{4'd13, 32'd123,        32'd456,        32'd0,          32'd0,          1'b0};

        do_reset();

        // Reset state.
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_bus", bus_out, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        for (int i = 0; i < N; i++) begin
            rd_addr = AW'(i);
            #1;
            check($sformatf("rst_r%0d", i), rd_data, 0);
        end

        // Directed vectors: operands in R2/R4, result in R5 (or HI/LO with R1 untouched).
        for (int i = 0; i < 14; i++) begin
            logic         long_op;
            logic [W-1:0] r1_before;
            long_op   = (vecs[i].op == 4'd10) || (vecs[i].op == 4'd11);
            load(4'd2, vecs[i].a);
            load(4'd4, vecs[i].b);
            r1_before = mreg[1];
            run_cmd(vecs[i].op, long_op ? 4'd1 : 4'd5, 4'd2, 4'd4);
            if (long_op) begin
                check($sformatf("vec%0d_lo", i), lo_out, vecs[i].lo);
                check($sformatf("vec%0d_hi", i), hi_out, vecs[i].hi);
                check($sformatf("vec%0d_r1", i), rd_data, r1_before);
                if (vecs[i].op == 4'd11) check($sformatf("vec%0d_dz", i), div_zero, vecs[i].dz);
            end else begin
                check($sformatf("vec%0d_res", i), rd_data, vecs[i].lo);
            end
            tick();
            check($sformatf("vec%0d_done_pulse", i), done, 0);
        end

        // Load wins over a simultaneous command; command goes the next cycle.
        load(4'd2, 32'd5);
        ld_valid = 1'b1; ld_addr = 4'd6; ld_data = 32'h66;
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_ra = 4'd7; cmd_rb = 4'd6; cmd_rc = 4'd6;
        #1;
        check("ld_cmd_ready", cmd_ready, 0);
        check("ld_cmd_bus", bus_out, 32'h66);
        tick();
        ld_valid = 1'b0;
        mreg[6] = 32'h66;
        #1;
        check("ld_cmd_not_taken", cmd_ready, 1);
        check("ld_cmd_no_done", done, 0);
        run_cmd(4'd0, 4'd7, 4'd6, 4'd6);
        check("ld_cmd_r7", rd_data, 32'hCC);

        // Back-to-back: second command accepted in the done cycle.
        check("b2b_done", done, 1);
        check("b2b_ready", cmd_ready, 1);
        run_cmd(4'd1, 4'd8, 4'd7, 4'd2);
        check("b2b_r8", rd_data, 32'hC7);
        run_cmd(4'd10, 4'd9, 4'd8, 4'd8);

        // ra aliases a source: old source values are used.
        run_cmd(4'd0, 4'd2, 4'd2, 4'd2);
        check("alias_r2", rd_data, 32'd10);

        // clr during T2 abandons the command.
        load(4'd3, 32'h55);
        rd_addr = 4'd3;
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_ra = 4'd3; cmd_rb = 4'd2; cmd_rc = 4'd2;
        tick();
        cmd_valid = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
        #1;
        check("clr_r3", rd_data, 0);
        check("clr_ready", cmd_ready, 1);
        for (int c = 0; c < 5; c++) begin
            check("clr_no_done", done, 0);
            tick();
        end

        // R0 hard-wired to zero only in the R0_ZERO build.
        load(4'd0, 32'd9);
        rd_addr = 4'd0;
        #1;
        check("r0_normal", rd_data, 32'd9);
        check("r0_zero", z_rd_data, 32'd0);

        // Randomized commands against the model.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                load(AW'($urandom), ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom));
            end
            run_cmd(4'($urandom), AW'($urandom), AW'($urandom), AW'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_datapath_seq.md
Name: bus_datapath_seq

Overview:
- Parametrised single-bus CPU datapath with an integrated micro-step sequencer.
- Contains a register file, Y, a double-width Z (ZHI/ZLO), HI/LO and an ALU, all sharing one bus.
- A host issues a register-register command over a valid/ready handshake. The block steps through the bus transfers (T1..T4) itself and pulses done when finished.
- Sits between the future control unit and memory/IO; the control unit issues commands instead of driving raw Rin/Rout strobes.

Parameters:
- WIDTH, 32, datapath and register width (>=8, power of two).
- NREGS, 16, number of general registers (power of two, >=2).
- R0_ZERO, 0, when 1, R0 reads as zero and writes to it are discarded.
- Derived, not overridable: AW = clog2(NREGS); SW = clog2(WIDTH).

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 NEG, 9 NOT, 10 MUL, 11 DIV; 12-15 reserved
- cmd_ra  in  AW  destination register
- cmd_rb  in  AW  first source
- cmd_rc  in  AW  second source
- ld_valid  in  1  direct register load request
- ld_addr  in  AW  load target
- ld_data  in  WIDTH  load value
- done  out  1  one-cycle completion pulse
- div_zero  out  1  sticky: the last DIV had a zero divisor
- bus_out  out  WIDTH  current bus value (observation)
- rd_addr  in  AW  debug read select
- rd_data  out  WIDTH  combinational R[rd_addr]
- hi_out, lo_out  out  WIDTH  HI and LO contents

Behaviour:
- Reset values:
  - clr at a clock edge sets all registers, Y, ZHI, ZLO, HI and LO to 0.
  - State returns to IDLE; done=0, div_zero=0.
  - An in-flight command is abandoned; none of its writes occur.
  - clr has priority over every other input.
- States: IDLE, T1, T2, T3, T4.
- Handshake:
  - cmd_ready = (state==IDLE) && !ld_valid && !clr.
  - A command is accepted at an edge where cmd_valid && cmd_ready.
  - op/ra/rb/rc are latched at acceptance; later changes to cmd_* are ignored.
- ld_valid in IDLE:
  - Bus = ld_data; R[ld_addr] is written at the same edge.
  - State stays IDLE and no done pulse is issued.
  - ld_valid has priority over cmd_valid in the same cycle.
  - ld_valid outside IDLE is ignored.
- T1: bus = R[rb]; Y <= bus.
- T2:
  - bus = R[rc].
  - Z <= ALU(Y, bus), a 2*WIDTH result.
  - For all ops except MUL/DIV: ZHI = 0, ZLO = result.
- T3:
  - bus = ZLO.
  - Non-MUL/DIV: R[ra] <= bus, then go to IDLE.
  - MUL/DIV: LO <= bus, then go to T4.
- T4: bus = ZHI; HI <= bus; then go to IDLE.
- done is a registered pulse, high for exactly one cycle: the first IDLE cycle after the final write.
  - Latency from the acceptance edge to done high is 3 cycles for most ops and 4 for MUL/DIV.
  - A new command may be accepted in the done cycle.
- Bus value in IDLE with no load: 0.
- ALU rules (Y = A, bus = B):
  - ADD/SUB: modulo 2^WIDTH; no carry out.
  - Shifts and rotates: amount = B[SW-1:0]. SHR is logical.
  - NEG = -A (two's complement), NOT = ~A; B is ignored.
  - MUL: signed WIDTH x WIDTH to 2*WIDTH; ZHI = upper half, ZLO = lower half.
  - DIV: unsigned. LO = A/B, HI = A%B.
    - B==0: LO = all ones, HI = A, div_zero <= 1.
    - Any DIV with B!=0 clears div_zero.
  - Reserved ops: result 0, written to R[ra] on the normal 3-cycle path.
- Register-index rules:
  - With R0_ZERO=1, any write to R0 (ld or T3) is discarded; R0 reads 0 on the bus and on rd_data.
  - ra may equal rb or rc. Sources are captured before the T3 write, so the old values are used.
- rd_data is combinational and reflects a write from the cycle after the write edge.

Test Plan:
- Reset then ld R2=5, R4=7; ADD ra=5 rb=2 rc=4 -> done 3 cycles after acceptance; R5=12; bus_out 5, 7, 12 in T1..T3; cmd_ready low in T1..T3.
- R2=0xFFFFFFFE, R4=3; MUL ra=1 rb=2 rc=4 -> LO=0xFFFFFFFA, HI=0xFFFFFFFF; done at +4 cycles; R1 unchanged.
- R2=17, R4=0; DIV -> LO=0xFFFFFFFF, HI=17, div_zero=1. Then DIV with R4=5 -> LO=3, HI=2, div_zero=0.
- ld_valid and cmd_valid asserted together in IDLE -> load completes and cmd_ready stays low. Command accepted the next cycle. Back-to-back command issued in the done cycle -> accepted with no idle gap.
- clr asserted in T2 of ADD ra=3 -> R3=0, state IDLE, no done pulse. R0_ZERO=1 build: ld R0=9 -> rd_data(R0)=0.
- ROL R2=0x80000001 by R4=33 -> rotate amount is 1 -> R5=0x00000003. SUB 3-5 -> 0xFFFFFFFE.
